// File: rtl/demux1t16_32_hs_if.sv
// Bus bundle for the 1-to-16 handshaked word distributor: upstream write port plus
// the shared-data, per-destination valid/ready downstream ports.
interface demux1t16_32_hs_if #(
    parameter int DW   = 32,
    parameter int NDST = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_sel;
    logic [DW-1:0]       in_data;
    logic                in_bcast;
    logic [NDST-1:0]     out_valid;
    logic [NDST-1:0]     out_ready;
    logic [DW-1:0]       out_data;
    logic                busy;

    // Environment side: drives the upstream word and the downstream accepts.
    modport master (
        output in_valid, in_sel, in_data, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Distributor side.
    modport slave (
        input  in_valid, in_sel, in_data, in_bcast, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/demux1t16_32_hs.sv
// Handshaked 1-to-16 distributor: holds one word and presents it to the selected
// destination until it is taken. Broadcast to all 16 is compiled in with DEMUX_BCAST_EN.
module demux1t16_32_hs #(
    parameter int DW   = 32,
    parameter int NDST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    demux1t16_32_hs_if.slave      bus,
    output logic                  state_dbg
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NDST-1:0] pend_q, pend_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NDST-1:0] still_pend;
    logic            accept;

    // Handshake: a transfer happens on a posedge where valid & ready are both high.
    // Upstream ready never depends on in_valid; a destination's valid only drops
    // after its own ready was seen high at an edge (or on reset).
    assign still_pend   = pend_q & ~bus.out_ready;
    assign bus.in_ready = ~|still_pend;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = pend_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = |pend_q;
    assign state_dbg     = state_q;

    always_comb begin
        pend_d = still_pend;
        data_d = data_q;
        if (accept) begin
            data_d = bus.in_data;
`ifdef DEMUX_BCAST_EN
            if (bus.in_bcast) begin
                pend_d = '1;
            end else begin
                pend_d = NDST'(1) << bus.in_sel;
            end
`else
            pend_d = NDST'(1) << bus.in_sel;
`endif
        end
    end

    // Two-state view mirrors pend: HOLD whenever any destination is pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = HOLD;
            HOLD: if (!accept && (still_pend == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_demux1t16_32_hs.sv
// Directed bench for demux1t16_32_hs: expected deliveries {dest,data} are queued at
// stimulus time and popped by a monitor at every destination handshake.
module tb_demux1t16_32_hs;
    localparam int DW = 32;
    localparam int W  = 36;

    logic clk;
    logic rst;
    logic state_dbg;

    demux1t16_32_hs_if #(.DW(DW), .NDST(16)) bus ();

    demux1t16_32_hs #(.DW(DW), .NDST(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [3:0] sel, input logic [DW-1:0] data,
                            input logic bcast);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = data;
        bus.in_bcast = bcast;
    endtask

    task automatic expect_word(input logic [3:0] dest, input logic [DW-1:0] data);
        exp_q.push_back({dest, data});
    endtask

    // Monitor: the handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_delivery dest=%0d data=%0h", i, bus.out_data);
                    end else begin
                        check("delivery", {32'h0, 4'(i), bus.out_data}, {28'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive_in(1'b0, 4'd0, '0, 1'b0);
        bus.out_ready = 16'h0000;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 16'h0000);
        check("rst_out_data",  bus.out_data,  32'h0);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_state",     state_dbg,     1'b0);
        rst = 1'b0;
        tick();

        // T2 unicast with stalled destination
        drive_in(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
        expect_word(4'd5, 32'hDEADBEEF);
        tick();
        drive_in(1'b0, 4'd0, '0, 1'b0);
        check("t2_out_valid", bus.out_valid, 16'h0020);
        check("t2_out_data",  bus.out_data,  32'hDEADBEEF);
        check("t2_in_ready",  bus.in_ready,  1'b0);
        check("t2_busy",      bus.busy,      1'b1);
        check("t2_state",     state_dbg,     1'b1);
        tick();
        check("t2_hold", bus.out_valid, 16'h0020);
        bus.out_ready = 16'h0020;
        #1;
        check("t2_in_ready_retire", bus.in_ready, 1'b1);
        tick();
        bus.out_ready = 16'h0000;
        check("t2_cleared",  bus.out_valid, 16'h0000);
        check("t2_idle",     state_dbg,     1'b0);

        // T3 back-to-back unicast
        bus.out_ready = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            drive_in(1'b1, 4'(k), 32'(k + 1), 1'b0);
            expect_word(4'(k), 32'(k + 1));
            #1;
            check("t3_in_ready", bus.in_ready, 1'b1);
            tick();
            check("t3_out_valid", bus.out_valid, 64'(16'h0001 << k));
            check("t3_out_data",  bus.out_data,  64'(k + 1));
        end
        drive_in(1'b0, 4'd0, '0, 1'b0);
        tick();
        check("t3_drained", bus.out_valid, 16'h0000);

        // T4 stall isolation; a competing upstream word must not be taken
        bus.out_ready = 16'h0000;
        drive_in(1'b1, 4'd9, 32'h12345678, 1'b0);
        expect_word(4'd9, 32'h12345678);
        tick();
        drive_in(1'b1, 4'd2, 32'hBAD0BAD0, 1'b0);
        bus.out_ready = 16'hFDFF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_out_valid", bus.out_valid, 16'h0200);
            check("t4_out_data",  bus.out_data,  32'h12345678);
            check("t4_in_ready",  bus.in_ready,  1'b0);
            tick();
        end
        drive_in(1'b0, 4'd0, '0, 1'b0);
        bus.out_ready = 16'h0200;
        tick();
        bus.out_ready = 16'h0000;
        check("t4_drained", bus.out_valid, 16'h0000);

        // T1 reset mid-HOLD discards the pending word
        drive_in(1'b1, 4'd5, 32'hCAFEF00D, 1'b0);
        tick();
        drive_in(1'b0, 4'd0, '0, 1'b0);
        check("t1_pending", bus.out_valid, 16'h0020);
        rst = 1'b1;
        #1;
        check("t1_out_valid", bus.out_valid, 16'h0000);
        check("t1_busy",      bus.busy,      1'b0);
        check("t1_in_ready",  bus.in_ready,  1'b1);
        check("t1_out_data",  bus.out_data,  32'h0);
        tick();
        rst = 1'b0;
        tick();

`ifdef DEMUX_BCAST_EN
        // T5 broadcast, staggered retirement, then retire-and-accept
        drive_in(1'b1, 4'd3, 32'hA5A5A5A5, 1'b1);
        for (int i = 0; i < 16; i++) expect_word(4'(i), 32'hA5A5A5A5);
        tick();
        drive_in(1'b0, 4'd0, '0, 1'b0);
        check("t5_all",  bus.out_valid, 16'hFFFF);
        check("t5_data", bus.out_data,  32'hA5A5A5A5);
        bus.out_ready = 16'h00FF;
        #1;
        check("t5_in_ready_part", bus.in_ready, 1'b0);
        tick();
        check("t5_ff00", bus.out_valid, 16'hFF00);
        bus.out_ready = 16'h7F00;
        tick();
        check("t5_8000", bus.out_valid, 16'h8000);
        bus.out_ready = 16'h8000;
        drive_in(1'b1, 4'd1, 32'h11111111, 1'b0);
        expect_word(4'd1, 32'h11111111);
        #1;
        check("t5_in_ready_last", bus.in_ready, 1'b1);
        tick();
        drive_in(1'b0, 4'd0, '0, 1'b0);
        check("t5_next_valid", bus.out_valid, 16'h0002);
        check("t5_next_data",  bus.out_data,  32'h11111111);
        bus.out_ready = 16'h0002;
        tick();
        bus.out_ready = 16'h0000;
        check("t5_drained", bus.out_valid, 16'h0000);
`else
        // T6 broadcast request is ignored without the feature
        drive_in(1'b1, 4'd3, 32'hA5A5A5A5, 1'b1);
        expect_word(4'd3, 32'hA5A5A5A5);
        tick();
        drive_in(1'b0, 4'd0, '0, 1'b0);
        check("t6_unicast", bus.out_valid, 16'h0008);
        check("t6_data",    bus.out_data,  32'hA5A5A5A5);
        bus.out_ready = 16'h0008;
        tick();
        bus.out_ready = 16'h0000;
        check("t6_drained", bus.out_valid, 16'h0000);
`endif

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
